// File: rtl/kgp_pkg.sv
// Shared widths and ALU control codes for the operand-fetch slice.
// XLEN/NREG are the default operand width and register count.
package kgp_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_MULT  = 4'b0001,
    ALU_MULTU = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_NOR   = 4'b0101,
    ALU_SLL   = 4'b0110,
    ALU_SRL   = 4'b0111,
    ALU_SRA   = 4'b1000
  } alu_ctrl_e;

endpackage

// File: rtl/operand_fetch_reg_file.sv
// 2R1W register file, r0 hardwired to zero, write-through bypass.
// Ports: clk/rst, write (we_i,waddr_i,wdata_i), reads raddr0/1_i -> rdata0/1_o.
module reg_file #(
  parameter int XLEN = kgp_pkg::XLEN,
  parameter int NREG = kgp_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr0_i,
  input  logic [4:0]      raddr1_i,
  output logic [XLEN-1:0] rdata0_o,
  output logic [XLEN-1:0] rdata1_o
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem_q [NREG];

  function automatic logic [XLEN-1:0] rd(
    input logic [4:0] a
  );
    if (a == 5'd0 || 32'(a) >= NREG)
      return '0;
    // Same-cycle write is visible to the read.
    if (we_i && waddr_i == a)
      return wdata_i;
    return mem_q[a[AW-1:0]];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        mem_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0
                 && 32'(waddr_i) < NREG) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata0_o = rd(raddr0_i);
  assign rdata1_o = rd(raddr1_i);

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: regfile read, scoreboard stall, output register to ALU.
// Ports: decode side in_*, writeback wb_*, ALU side out_*.
module operand_fetch #(
  parameter int XLEN = kgp_pkg::XLEN,
  parameter int NREG = kgp_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs,
  input  logic [4:0]      in_rt,
  input  logic [4:0]      in_rd,
  input  logic            in_wr,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_imm,
  input  logic [3:0]      in_ctrl,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand0,
  output logic [XLEN-1:0] out_operand1,
  output logic [3:0]      out_control,
  output logic [4:0]      out_rd,
  output logic            out_wr
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] rd0, rd1;
  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] set_v, clr_v;
  logic            pend_rs, pend_rt;
  logic            clr_rs, clr_rt;
  logic            hazard, xfer;

  logic            vld_q, vld_d;
  logic [XLEN-1:0] op0_q, op0_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [3:0]      ctl_q, ctl_d;
  logic [4:0]      rd_q, rd_d;
  logic            wr_q, wr_d;

  reg_file #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr0_i (in_rs),
    .raddr1_i (in_rt),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );

  assign pend_rs = (32'(in_rs) < NREG)
                && pend_q[in_rs[AW-1:0]];
  assign pend_rt = (32'(in_rt) < NREG)
                && pend_q[in_rt[AW-1:0]];
  assign clr_rs  = wb_en && wb_addr == in_rs;
  assign clr_rt  = wb_en && wb_addr == in_rt;

  // A writeback landing this cycle resolves the hazard via bypass.
  assign hazard =
    (in_rs != 5'd0 && pend_rs && !clr_rs) ||
    (!in_use_imm && in_rt != 5'd0
     && pend_rt && !clr_rt);

  assign in_ready = (!vld_q || out_ready) && !hazard;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int i = 1; i < NREG; i++) begin
      set_v[i] = xfer && in_wr && in_rd == 5'(i);
      clr_v[i] = wb_en && wb_addr == 5'(i);
    end
    // Set wins over a same-cycle clear.
    pend_d = (pend_q & ~clr_v) | set_v;
  end

  always_comb begin
    vld_d = vld_q;
    op0_d = op0_q;
    op1_d = op1_q;
    ctl_d = ctl_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (xfer) begin
      vld_d = 1'b1;
      op0_d = rd0;
      op1_d = in_use_imm ? in_imm : rd1;
      ctl_d = in_ctrl;
      rd_d  = in_rd;
      wr_d  = in_wr;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      vld_q  <= 1'b0;
      op0_q  <= '0;
      op1_q  <= '0;
      ctl_q  <= '0;
      rd_q   <= '0;
      wr_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      vld_q  <= vld_d;
      op0_q  <= op0_d;
      op1_q  <= op1_d;
      ctl_q  <= ctl_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  assign out_valid    = vld_q;
  assign out_operand0 = op0_q;
  assign out_operand1 = op1_q;
  assign out_control  = ctl_q;
  assign out_rd       = rd_q;
  assign out_wr       = wr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized + directed bench for operand_fetch.
// Reference model: register array, pending flags, output snapshot.
module tb_operand_fetch;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [4:0]      in_rs, in_rt, in_rd;
  logic            in_wr, in_use_imm;
  logic [XLEN-1:0] in_imm;
  logic [3:0]      in_ctrl;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_operand0, out_operand1;
  logic [3:0]      out_control;
  logic [4:0]      out_rd;
  logic            out_wr;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_wr        (in_wr),
    .in_use_imm   (in_use_imm),
    .in_imm       (in_imm),
    .in_ctrl      (in_ctrl),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_operand0 (out_operand0),
    .out_operand1 (out_operand1),
    .out_control  (out_control),
    .out_rd       (out_rd),
    .out_wr       (out_wr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_pend [NREG];
  bit              m_ov;
  logic [XLEN-1:0] m_op0, m_op1;
  logic [3:0]      m_ctl;
  logic [4:0]      m_rd;
  bit              m_wr;

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_ov = 0; m_op0 = '0; m_op1 = '0;
    m_ctl = '0; m_rd = '0; m_wr = 0;
  endtask

  function automatic logic [XLEN-1:0] m_read(
    input logic [4:0] a
  );
    if (a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    return a != 0 && m_pend[a]
        && !(wb_en && wb_addr == a);
  endfunction

  function automatic bit m_rdy();
    bit hz;
    hz = m_busy(in_rs)
      || (!in_use_imm && m_busy(in_rt));
    return (!m_ov || out_ready) && !hz;
  endfunction

  task automatic chk_out(input string p);
    check({p, ".valid"}, 64'(out_valid), 64'(m_ov));
    check({p, ".op0"}, 64'(out_operand0), 64'(m_op0));
    check({p, ".op1"}, 64'(out_operand1), 64'(m_op1));
    check({p, ".ctl"}, 64'(out_control), 64'(m_ctl));
    check({p, ".rd"}, 64'(out_rd), 64'(m_rd));
    check({p, ".wr"}, 64'(out_wr), 64'(m_wr));
  endtask

  // One clock: check in_ready, advance model, check outputs.
  task automatic step(input string p);
    bit              xf, rdy;
    logic [XLEN-1:0] a0, a1;
    #1;
    rdy = m_rdy();
    check({p, ".in_ready"}, 64'(in_ready), 64'(rdy));
    xf = in_valid && rdy;
    a0 = m_read(in_rs);
    a1 = in_use_imm ? in_imm : m_read(in_rt);
    @(posedge clk);
    if (xf) begin
      m_ov = 1; m_op0 = a0; m_op1 = a1;
      m_ctl = in_ctrl; m_rd = in_rd; m_wr = in_wr;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (wb_en && wb_addr != 0) begin
      m_reg[wb_addr]  = wb_data;
      m_pend[wb_addr] = 1'b0;
    end
    if (xf && in_wr && in_rd != 0)
      m_pend[in_rd] = 1'b1;
    #1;
    chk_out(p);
  endtask

  task automatic idle();
    in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0;
    in_wr = 0; in_use_imm = 0; in_imm = '0;
    in_ctrl = kgp_pkg::ALU_ADD;
    wb_en = 0; wb_addr = 0; wb_data = '0;
    out_ready = 1;
  endtask

  task automatic issue(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic wr
  );
    in_valid = 1; in_rs = rs; in_rt = rt;
    in_rd = rd; in_wr = wr; in_use_imm = 0;
  endtask

  task automatic wb(input logic [4:0] a,
                    input logic [XLEN-1:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    idle();
    m_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst");
    check("rst.pend", 64'(dut.pend_q), 64'(0));
    rst = 0;

    // S1: write r5, then read it.
    wb(5'd5, 32'h0000_00A5);
    step("s1a");
    idle();
    issue(5'd5, 5'd0, 5'd0, 0);
    step("s1b");
    check("s1.op0", 64'(out_operand0), 64'hA5);
    check("s1.op1", 64'(out_operand1), 64'h0);
    check("s1.vld", 64'(out_valid), 64'h1);

    // S2: same-cycle writeback bypass.
    idle();
    wb(5'd3, 32'h1234);
    issue(5'd3, 5'd0, 5'd0, 0);
    step("s2");
    check("s2.op0", 64'(out_operand0), 64'h1234);

    // S3: RAW stall on r7 until writeback.
    idle();
    issue(5'd0, 5'd0, 5'd7, 1);
    step("s3a");
    idle();
    issue(5'd7, 5'd0, 5'd0, 0);
    #1;
    check("s3.stall", 64'(in_ready), 64'h0);
    step("s3b");
    wb(5'd7, 32'hDEAD);
    #1;
    check("s3.go", 64'(in_ready), 64'h1);
    step("s3c");
    check("s3.op0", 64'(out_operand0), 64'hDEAD);

    // S4: back-pressure for 3 cycles.
    idle();
    issue(5'd5, 5'd0, 5'd0, 0);
    step("s4a");
    issue(5'd3, 5'd0, 5'd0, 0);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s4.hold_rdy", 64'(in_ready), 64'h0);
      step("s4h");
      check("s4.hold_op0", 64'(out_operand0), 64'hA5);
    end
    out_ready = 1;
    #1;
    check("s4.rel_rdy", 64'(in_ready), 64'h1);
    step("s4r");
    check("s4.op0", 64'(out_operand0), 64'h1234);

    // S5: immediate bypasses pending rt.
    idle();
    issue(5'd0, 5'd0, 5'd9, 1);
    step("s5a");
    idle();
    issue(5'd0, 5'd9, 5'd0, 0);
    in_use_imm = 1;
    in_imm = 32'hFFFF_FFF0;
    #1;
    check("s5.rdy", 64'(in_ready), 64'h1);
    step("s5b");
    check("s5.op1", 64'(out_operand1), 64'hFFFF_FFF0);

    // S6: r0 writes ignored; pending[0] never set.
    idle();
    wb(5'd0, 32'hFFFF_FFFF);
    issue(5'd0, 5'd0, 5'd0, 1);
    step("s6a");
    idle();
    issue(5'd0, 5'd0, 5'd0, 0);
    step("s6b");
    check("s6.op0", 64'(out_operand0), 64'h0);
    check("s6.pend0", 64'(dut.pend_q[0]), 64'h0);
    wb(5'd9, 32'h99);
    in_valid = 0;
    step("s6c");

    // Random traffic with one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        in_valid = 1;
        rst = 1;
        #1;
        m_reset();
        chk_out("mrst");
        @(posedge clk);
        #1;
        chk_out("mrst2");
        rst = 0;
      end
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rs      = 5'($urandom_range(0, 7));
      in_rt      = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 7));
      in_wr      = 1'($urandom);
      in_use_imm = ($urandom_range(0, 3) == 0);
      in_imm     = $urandom;
      in_ctrl    = 4'($urandom_range(0, 8));
      wb_en      = 1'($urandom);
      wb_addr    = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      out_ready  = ($urandom_range(0, 9) < 7);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
